mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read data memory (DMEM/IMEM-style block RAM, 1-cycle read latency) between two requesters: the CPU memory stage and a DMA/loader engine.
- Issues at most one access per cycle and routes each read response back to the requester that issued it.
- CPU has priority. A saturating starvation counter guarantees the DMA forward progress.
- Sits between the memory stage / DMA engine and the RAM primitive.

Parameters:
- AWIDTH, 14, word-address width into the memory.
- DWIDTH, 32, data width (byte-enable width is DWIDTH/8).
- STARVE_LIMIT, 4, consecutive denied DMA cycles before the DMA is force-granted. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  CPU request accepted this cycle.
- cpu_req_addr  in  AWIDTH  CPU word address.
- cpu_req_we  in  DWIDTH/8  CPU byte write enables; 0 means read.
- cpu_req_wdata  in  DWIDTH  CPU write data.
- cpu_resp_valid  out  1  CPU read data valid (one-cycle pulse).
- cpu_resp_rdata  out  DWIDTH  CPU read data.
- dma_req_valid, dma_req_ready, dma_req_addr, dma_req_we, dma_req_wdata  same as the CPU request ports, for the DMA.
- dma_resp_valid, dma_resp_rdata  same as the CPU response ports, for the DMA.
- mem_en  out  1  memory access enable.
- mem_we  out  DWIDTH/8  memory byte write enables.
- mem_addr  out  AWIDTH  memory address.
- mem_din  out  DWIDTH  memory write data.
- mem_dout  in  DWIDTH  memory read data, valid one cycle after a read issue.
- dma_starve_cnt  out  4  current starvation count (debug).

Behaviour:
Grant logic (combinational, same cycle as the request):
- force_dma = dma_req_valid && (dma_starve_cnt == STARVE_LIMIT).
- grant_dma = dma_req_valid && (!cpu_req_valid || force_dma).
- grant_cpu = cpu_req_valid && !grant_dma.
- Each *_req_ready equals its grant. The handshake completes when valid && ready.
- Requesters must not derive valid from ready (no combinational loops).

Memory drive:
- mem_en = grant_cpu || grant_dma.
- mem_addr, mem_we and mem_din are muxed from the winner.
- When idle: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.

Starvation counter (registered):
- Increments when dma_req_valid && !grant_dma, saturating at STARVE_LIMIT.
- Clears to 0 on grant_dma, or when dma_req_valid=0.

Read responses:
- A read is an accepted request with we==0.
- A registered 2-bit tag {rd_cpu, rd_dma} captures read issue.
- Exactly one cycle later, the matching *_resp_valid=1 and *_resp_rdata=mem_dout.
- The non-matching requester's resp_valid=0 and its rdata=0.
- No response backpressure; requesters must sink responses.

Writes:
- Produce no response.
- Partial byte-enables pass through unchanged.
- Back-to-back write then read to the same address returns the new data, because issue order is preserved.

Reset:
- While rst_n=0 at a clock edge: tag, counter, all *_resp_valid and all *_resp_rdata clear to 0.
- A read issued in the cycle before reset yields no response.
- All combinational outputs are 0 while rst_n=0: readies, mem_en and the other mem_* drive outputs are gated by rst_n.

Simultaneous events:
- Both requesters valid and counter below the limit: CPU wins.
- Both valid and counter at the limit: DMA wins and the CPU waits exactly one cycle.
- STARVE_LIMIT=1 with both continuously valid gives strict alternation C,D,C,D.

Test Plan:
1. CPU read only, addr 0x10, RAM[0x10]=0xDEADBEEF:
   - Same cycle: cpu_req_ready=1, mem_en=1, mem_addr=0x10, mem_we=0.
   - Next cycle: cpu_resp_valid=1, rdata=0xDEADBEEF, dma_resp_valid=0.
2. Both requesters continuously valid, STARVE_LIMIT=4:
   - Grants follow C,C,C,C,D,C,C,C,C,D.
   - dma_starve_cnt follows 1,2,3,4,0,1,...
3. DMA write alone, addr 5, we=4'hF, data 0x12345678:
   - Granted the same cycle; no resp_valid.
   - A following CPU read of addr 5 returns 0x12345678 one cycle after issue.
4. CPU write to addr 7 with we=4'b0010, data 0xAABBCCDD:
   - mem_we=4'b0010, mem_din=0xAABBCCDD, mem_addr=7.
5. Both valid, DMA denied 3 cycles, dma_req_valid drops 1 cycle, then reasserts:
   - Counter resets to 0.
   - DMA is granted only after 4 further denied cycles.
6. CPU read issued, rst_n=0 on the next edge:
   - No cpu_resp_valid.
   - All outputs 0 during reset; counter 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, synchronous-read memory (1-cycle read latency)
//   between the CPU memory stage and a DMA/loader engine. At most one access
//   is issued per cycle; read data is routed back to whichever requester
//   issued the read. The CPU has priority, and a saturating starvation
//   counter force-grants the DMA after STARVE_LIMIT consecutive denied cycles.
//
// Handshake: a request transfers in the cycle where *_req_valid && *_req_ready.
//   Ready is a combinational function of both valids and the starvation count,
//   so requesters must not derive valid from ready. Responses have no
//   backpressure: *_resp_valid is a one-cycle pulse that must be sunk.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_req_*                  CPU request (valid/ready/addr/we/wdata)
//   cpu_resp_valid/rdata       CPU read response, one cycle after issue
//   dma_req_*                  DMA request (valid/ready/addr/we/wdata)
//   dma_resp_valid/rdata       DMA read response, one cycle after issue
//   mem_en/we/addr/din         drive into the RAM primitive
//   mem_dout                   RAM read data, valid one cycle after a read issue
//   dma_starve_cnt             current starvation count (debug/observability)
module mem_port_arbiter #(
  parameter int AWIDTH       = 14,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic [AWIDTH-1:0]   cpu_req_addr,
  input  logic [DWIDTH/8-1:0] cpu_req_we,
  input  logic [DWIDTH-1:0]   cpu_req_wdata,
  output logic                cpu_resp_valid,
  output logic [DWIDTH-1:0]   cpu_resp_rdata,
  input  logic                dma_req_valid,
  output logic                dma_req_ready,
  input  logic [AWIDTH-1:0]   dma_req_addr,
  input  logic [DWIDTH/8-1:0] dma_req_we,
  input  logic [DWIDTH-1:0]   dma_req_wdata,
  output logic                dma_resp_valid,
  output logic [DWIDTH-1:0]   dma_resp_rdata,
  output logic                mem_en,
  output logic [DWIDTH/8-1:0] mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_din,
  input  logic [DWIDTH-1:0]   mem_dout,
  output logic [3:0]          dma_starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic       force_dma;
  logic       grant_dma;
  logic       grant_cpu;
  // Read-issue tag: which requester owns the data mem_dout shows next cycle.
  logic       rd_cpu_q;
  logic       rd_dma_q;

  // Grants are gated by rst_n so nothing reaches the RAM during reset.
  always_comb begin
    force_dma = rst_n && dma_req_valid && (starve_cnt_q == LIMIT);
    grant_dma = rst_n && dma_req_valid && (!cpu_req_valid || force_dma);
    grant_cpu = rst_n && cpu_req_valid && !grant_dma;
  end

  assign cpu_req_ready  = grant_cpu;
  assign dma_req_ready  = grant_dma;
  assign dma_starve_cnt = starve_cnt_q;

  // Memory drive: winner's request, all zero when idle.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_cpu) begin
      mem_en   = 1'b1;
      mem_we   = cpu_req_we;
      mem_addr = cpu_req_addr;
      mem_din  = cpu_req_wdata;
    end else if (grant_dma) begin
      mem_en   = 1'b1;
      mem_we   = dma_req_we;
      mem_addr = dma_req_addr;
      mem_din  = dma_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rd_cpu_q     <= 1'b0;
      rd_dma_q     <= 1'b0;
    end else begin
      // Count only consecutive denied cycles; a dropped request restarts it.
      if (!dma_req_valid || grant_dma) begin
        starve_cnt_q <= '0;
      end else if (starve_cnt_q < LIMIT) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end
      rd_cpu_q <= grant_cpu && (cpu_req_we == '0);
      rd_dma_q <= grant_dma && (dma_req_we == '0);
    end
  end

  // The RAM output register supplies the data; the tag only steers it. The
  // non-owning side sees zero so stale RAM data never leaks across ports.
  always_comb begin
    cpu_resp_valid = rst_n && rd_cpu_q;
    dma_resp_valid = rst_n && rd_dma_q;
    cpu_resp_rdata = cpu_resp_valid ? mem_dout : '0;
    dma_resp_rdata = dma_resp_valid ? mem_dout : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural 1-cycle-latency RAM on the
// memory side, a reference memory plus starvation-counter model for
// expectations, and per-requester expected-read-data queues.
module tb_mem_port_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req_valid = 1'b0, cpu_req_ready;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [BW-1:0] cpu_req_we = '0;
  logic [DW-1:0] cpu_req_wdata = '0;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_rdata;
  logic          dma_req_valid = 1'b0, dma_req_ready;
  logic [AW-1:0] dma_req_addr = '0;
  logic [BW-1:0] dma_req_we = '0;
  logic [DW-1:0] dma_req_wdata = '0;
  logic          dma_resp_valid;
  logic [DW-1:0] dma_resp_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [3:0]    dma_starve_cnt;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_addr(dma_req_addr), .dma_req_we(dma_req_we),
    .dma_req_wdata(dma_req_wdata),
    .dma_resp_valid(dma_resp_valid), .dma_resp_rdata(dma_resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .dma_starve_cnt(dma_starve_cnt)
  );

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != '0) begin
        for (int b = 0; b < BW; b++)
          if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= ram[mem_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] cpu_exp_q[$];
  logic [DW-1:0] dma_exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int m_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [BW-1:0] we,
                           input logic [DW-1:0] d);
    for (int b = 0; b < BW; b++)
      if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // One clock cycle: drive at negedge, check #1 later, return at next negedge.
  task automatic step(input logic rst,
                      input logic cv, input logic [AW-1:0] ca,
                      input logic [BW-1:0] cw, input logic [DW-1:0] cd,
                      input logic dv, input logic [AW-1:0] da,
                      input logic [BW-1:0] dw, input logic [DW-1:0] dd,
                      output logic gc, output logic gd);
    logic          fd;
    logic [AW-1:0] ea;
    logic [BW-1:0] ew;
    logic [DW-1:0] ed;
    rst_n = rst;
    cpu_req_valid = cv; cpu_req_addr = ca; cpu_req_we = cw; cpu_req_wdata = cd;
    dma_req_valid = dv; dma_req_addr = da; dma_req_we = dw; dma_req_wdata = dd;
    #1;
    gc = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      chk("rst_cpu_ready", 32'(cpu_req_ready), 0);
      chk("rst_dma_ready", 32'(dma_req_ready), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_cpu_resp_valid", 32'(cpu_resp_valid), 0);
      chk("rst_dma_resp_valid", 32'(dma_resp_valid), 0);
      chk("rst_cpu_rdata", cpu_resp_rdata, 0);
      chk("rst_dma_rdata", dma_resp_rdata, 0);
      cpu_exp_q.delete();
      dma_exp_q.delete();
      m_cnt = 0;
    end else begin
      chk("cpu_resp_valid", 32'(cpu_resp_valid), 32'(cpu_exp_q.size() != 0));
      if (cpu_exp_q.size() != 0) chk("cpu_resp_rdata", cpu_resp_rdata, cpu_exp_q.pop_front());
      else                       chk("cpu_rdata_idle", cpu_resp_rdata, 0);
      chk("dma_resp_valid", 32'(dma_resp_valid), 32'(dma_exp_q.size() != 0));
      if (dma_exp_q.size() != 0) chk("dma_resp_rdata", dma_resp_rdata, dma_exp_q.pop_front());
      else                       chk("dma_rdata_idle", dma_resp_rdata, 0);
      chk("starve_cnt", 32'(dma_starve_cnt), m_cnt);

      fd = dv && (m_cnt == LIMIT);
      gd = dv && (!cv || fd);
      gc = cv && !gd;
      ea = gc ? ca : (gd ? da : '0);
      ew = gc ? cw : (gd ? dw : '0);
      ed = gc ? cd : (gd ? dd : '0);
      chk("cpu_req_ready", 32'(cpu_req_ready), 32'(gc));
      chk("dma_req_ready", 32'(dma_req_ready), 32'(gd));
      chk("mem_en", 32'(mem_en), 32'(gc || gd));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_we", 32'(mem_we), 32'(ew));
      chk("mem_din", mem_din, ed);

      if (gc) begin
        if (cw == '0) cpu_exp_q.push_back(ref_mem[ca]);
        else          ref_write(ca, cw, cd);
      end
      if (gd) begin
        if (dw == '0) dma_exp_q.push_back(ref_mem[da]);
        else          ref_write(da, dw, dd);
      end
      if (!dv || gd)         m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    logic gc, gd;
    step(rst, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, gc, gd);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic gc, gd;
    logic [9:0] dseq;
    int exp_cnt[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    int denials;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = i * 32'h9E3779B1;
      ref_mem[i] = i * 32'h9E3779B1;
    end
    ram[14'h10]     = 32'hDEADBEEF;
    ref_mem[14'h10] = 32'hDEADBEEF;

    @(negedge clk);
    idle(1'b0);
    idle(1'b0);

    // 1: lone CPU read of 0x10
    step(1'b1, 1'b1, 14'h10, 4'h0, '0, 1'b0, '0, '0, '0, gc, gd);
    idle(1'b1);

    // 2: both valid continuously, reads
    dseq = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 14'(32'h20 + i), 4'h0, '0, 1'b1, 14'(32'h40 + i), 4'h0, '0, gc, gd);
      dseq[i] = gd;
      chk("t2_cnt_seq", 32'(dma_starve_cnt), exp_cnt[i]);
    end
    chk("t2_grant_seq", 32'(dseq), 32'h210);
    idle(1'b1);

    // 3: DMA full write to 5, then CPU read of 5
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, 14'd5, 4'hF, 32'h12345678, gc, gd);
    chk("t3_dma_granted", 32'(gd), 1);
    step(1'b1, 1'b1, 14'd5, 4'h0, '0, 1'b0, '0, '0, '0, gc, gd);
    idle(1'b1);
    chk("t3_ref_value", ref_mem[5], 32'h12345678);

    // 4: CPU partial write to 7, then read back the merged word
    step(1'b1, 1'b1, 14'd7, 4'b0010, 32'hAABBCCDD, 1'b0, '0, '0, '0, gc, gd);
    step(1'b1, 1'b1, 14'd7, 4'h0, '0, 1'b0, '0, '0, '0, gc, gd);
    idle(1'b1);

    // 5: DMA denied 3 cycles, drops 1 cycle, then needs 4 fresh denials
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 14'(32'h60 + i), 4'h0, '0, 1'b1, 14'h70, 4'h0, '0, gc, gd);
    step(1'b1, 1'b1, 14'h63, 4'h0, '0, 1'b0, '0, '0, '0, gc, gd);
    chk("t5_cnt_cleared", 32'(dma_starve_cnt), 0);
    denials = 0;
    gd = 1'b0;
    for (int i = 0; i < 8 && !gd; i++) begin
      step(1'b1, 1'b1, 14'(32'h64 + i), 4'h0, '0, 1'b1, 14'h71, 4'h0, '0, gc, gd);
      if (!gd) denials++;
    end
    chk("t5_denials", denials, 4);
    idle(1'b1);

    // 6: read issued, then reset: response is dropped
    step(1'b1, 1'b1, 14'h10, 4'h0, '0, 1'b1, 14'h11, 4'h0, '0, gc, gd);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("t6_cnt_after_rst", 32'(dma_starve_cnt), 0);

    // random traffic over a small address window
    for (int i = 0; i < 60; i++) begin
      step(1'b1,
           1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom,
           1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom,
           gc, gd);
    end
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
